// File: rtl/io_port_ctrl_pkg.sv
// Shared constants for the io_port_ctrl peripheral: port address map and
// default debounce sizing.
package io_port_pkg;

  localparam logic [7:0] PORT_LED        = 8'h00;
  localparam logic [7:0] PORT_SEG_LO     = 8'h01;
  localparam logic [7:0] PORT_SEG_HI     = 8'h02;
  localparam logic [7:0] PORT_IRQ_MASK_W = 8'h03;

  localparam logic [7:0] PORT_SW         = 8'h00;
  localparam logic [7:0] PORT_BTN_LVL    = 8'h01;
  localparam logic [7:0] PORT_BTN_EVT    = 8'h02;
  localparam logic [7:0] PORT_LED_RB     = 8'h03;
  localparam logic [7:0] PORT_IRQ_MASK_R = 8'h04;

  localparam int unsigned DEFAULT_DEBOUNCE = 250000;
  localparam int unsigned DEFAULT_CNT_W    = 18;

endpackage

// File: rtl/io_port_ctrl_btn_debounce.sv
// One push-button: 2-flop synchroniser, stability counter, and a pulse that
// is high in the cycle whose clock edge raises the debounced level.
module btn_debounce
  import io_port_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_done;

  assign w_done  = (r_sync2 != r_level) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign o_level = r_level;
  // Asserted one cycle early so the event flag sets on the same edge as the level.
  assign o_rise  = w_done && !r_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped LED / 7-seg / switch / button peripheral for the 8-bit core.
// Define IO_PORT_CTRL_IRQ_EN to add the irq_mask register and registered irq.
module io_port_ctrl
  import io_port_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_data,
  input  logic               write_strobe,
  input  logic               read_strobe,
  output logic [7:0]         in_data,
  input  logic [7:0]         sw,
  input  logic [NUM_BTN-1:0] btn,
  output logic [7:0]         led,
  output logic [15:0]        seg_data,
  output logic               irq
);

  logic [7:0]         r_led;
  logic [15:0]        r_seg;
  logic [7:0]         r_sw_meta;
  logic [7:0]         r_sw_sync;
  logic [NUM_BTN-1:0] r_flags;
  logic [NUM_BTN-1:0] w_lvl;
  logic [NUM_BTN-1:0] w_rise;
  logic               w_evt_clr;
  logic [7:0]         w_lvl8;
  logic [7:0]         w_flags8;
  logic [7:0]         w_mask_rd;

  assign led      = r_led;
  assign seg_data = r_seg;

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_btn (
        .clk    (clk),
        .reset  (reset),
        .i_btn  (btn[g]),
        .o_level(w_lvl[g]),
        .o_rise (w_rise[g])
      );
    end
  endgenerate

  assign w_evt_clr = read_strobe && (port_id == PORT_BTN_EVT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_flags   <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      // Set after clear: a rise coinciding with the read stays pending.
      r_flags   <= (r_flags & ~{NUM_BTN{w_evt_clr}}) | w_rise;
    end
  end

`ifdef IO_PORT_CTRL_IRQ_EN
  logic [7:0] r_mask;
  logic       r_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (write_strobe && (port_id == PORT_IRQ_MASK_W)) r_mask <= out_data;
      r_irq <= |(r_flags & r_mask[NUM_BTN-1:0]);
    end
  end

  assign irq       = r_irq;
  assign w_mask_rd = r_mask;
`else
  assign irq       = 1'b0;
  assign w_mask_rd = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led <= '0;
      r_seg <= '0;
    end else if (write_strobe) begin
      case (port_id)
        PORT_LED:    r_led       <= out_data;
        PORT_SEG_LO: r_seg[7:0]  <= out_data;
        PORT_SEG_HI: r_seg[15:8] <= out_data;
        default:     ;
      endcase
    end
  end

  always_comb begin
    w_lvl8                = '0;
    w_flags8              = '0;
    w_lvl8[NUM_BTN-1:0]   = w_lvl;
    w_flags8[NUM_BTN-1:0] = r_flags;
    case (port_id)
      PORT_SW:         in_data = r_sw_sync;
      PORT_BTN_LVL:    in_data = w_lvl8;
      PORT_BTN_EVT:    in_data = w_flags8;
      PORT_LED_RB:     in_data = r_led;
      PORT_IRQ_MASK_R: in_data = w_mask_rd;
      default:         in_data = '0;
    endcase
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl with a short debounce window (8 cycles).
module tb_io_port_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] port_id;
  logic [7:0] out_data;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_data;
  logic [7:0] sw;
  logic [3:0] btn;
  logic [7:0] led;
  logic [15:0] seg_data;
  logic       irq;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef IO_PORT_CTRL_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  io_port_ctrl #(
    .NUM_BTN        (4),
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .port_id     (port_id),
    .out_data    (out_data),
    .write_strobe(write_strobe),
    .read_strobe (read_strobe),
    .in_data     (in_data),
    .sw          (sw),
    .btn         (btn),
    .led         (led),
    .seg_data    (seg_data),
    .irq         (irq)
  );

  always #10 clk = ~clk;

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [7:0] p, input logic [7:0] exp);
    port_id = p;
    #1;
    chk(tag, {24'h0, in_data}, {24'h0, exp});
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    port_id = p; out_data = d; write_strobe = 1'b1;
    tick(1);
    write_strobe = 1'b0;
  endtask

  task automatic clr_rd;
    port_id = 8'h02; read_strobe = 1'b1;
    tick(1);
    read_strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; port_id = '0; out_data = '0; write_strobe = 1'b0;
    read_strobe = 1'b0; sw = '0; btn = '0;
    tick(2);
    reset = 1'b0;
    chk("rst_led", {24'h0, led}, 32'h00);
    chk("rst_seg", {16'h0, seg_data}, 32'h0000);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rd("rst_lvl", 8'h01, 8'h00);
    rd("rst_evt", 8'h02, 8'h00);

    wr(8'h00, 8'hA5);
    chk("led_wr", {24'h0, led}, 32'hA5);
    rd("led_rb", 8'h03, 8'hA5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("led_rst", {24'h0, led}, 32'h00);

    wr(8'h01, 8'h34);
    wr(8'h02, 8'h12);
    chk("seg_wr", {16'h0, seg_data}, 32'h1234);
    wr(8'h00, 8'h5A);
    wr(8'h07, 8'hFF);
    chk("wr07_led", {24'h0, led}, 32'h5A);
    chk("wr07_seg", {16'h0, seg_data}, 32'h1234);
    wr(8'h03, 8'h01);  // irq mask; ignored without the macro
    rd("mask_rb", 8'h04, IRQ_ON ? 8'h01 : 8'h00);
    chk("mask_led", {24'h0, led}, 32'h5A);

    #3 sw = 8'h3C;
    tick(1);
    rd("sw_1edge", 8'h00, 8'h00);
    tick(1);
    rd("sw_2edge", 8'h00, 8'h3C);
    rd("rd_unmap", 8'h55, 8'h00);

    btn = 4'b0010;
    tick(5);
    btn = 4'b0000;
    tick(10);
    rd("glitch_lvl", 8'h01, 8'h00);
    rd("glitch_evt", 8'h02, 8'h00);

    btn = 4'b0010;
    tick(9);
    rd("hold9_lvl", 8'h01, 8'h00);
    tick(1);
    rd("hold10_lvl", 8'h01, 8'h02);
    rd("hold10_evt", 8'h02, 8'h02);
    tick(2);
    chk("hold_irq", {31'h0, irq}, 32'h0);

    clr_rd();
    rd("clr_evt", 8'h02, 8'h00);
    rd("clr_lvl", 8'h01, 8'h02);

    btn = 4'b0011;
    tick(9);
    clr_rd();
    rd("same_edge_evt", 8'h02, 8'h01);
    rd("same_edge_lvl", 8'h01, 8'h03);
    clr_rd();
    rd("clr2_evt", 8'h02, 8'h00);

    btn = 4'b0111;
    tick(10);
    rd("b2_evt", 8'h02, 8'h04);
    tick(1);
    chk("b2_masked_irq", {31'h0, irq}, 32'h0);

    btn = 4'b0110;
    tick(12);
    rd("b0_rel_lvl", 8'h01, 8'h06);
    rd("b0_rel_evt", 8'h02, 8'h04);
    btn = 4'b0111;
    tick(10);
    rd("b0_evt", 8'h02, 8'h05);
    chk("b0_irq_pre", {31'h0, irq}, 32'h0);
    tick(1);
    chk("b0_irq", {31'h0, irq}, {31'h0, IRQ_ON});
    clr_rd();
    rd("irq_clr_evt", 8'h02, 8'h00);
    chk("irq_clr_hold", {31'h0, irq}, {31'h0, IRQ_ON});
    tick(1);
    chk("irq_clr", {31'h0, irq}, 32'h0);

    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    rd("mid_rst_lvl", 8'h01, 8'h00);
    rd("mid_rst_mask", 8'h04, 8'h00);
    tick(9);
    rd("mid_rst_lvl9", 8'h01, 8'h00);
    tick(1);
    rd("mid_rst_lvl10", 8'h01, 8'h07);
    rd("mid_rst_evt", 8'h02, 8'h07);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/io_port_ctrl.md
Name: io_port_ctrl

Overview:
- Memory-mapped I/O peripheral directly downstream of the 8-bit processor core.
- Consumes the core's port_id, out_data and write_strobe, plus a read_strobe.
- Produces the core's in_data.
- Latches LED and 7-segment output registers; synchronises switches; debounces push-buttons and captures press events in sticky flags that clear on read.

Parameters:
- NUM_BTN, 4, number of push-buttons (1..8).
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles before a button level is accepted (2.5 ms at 100 MHz).
- CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, shared with the core.
- reset  input  1  synchronous, active-high reset.
- port_id  input  8  port address from the core.
- out_data  input  8  write data from the core.
- write_strobe  input  1  one-cycle write qualifier.
- read_strobe  input  1  one-cycle read qualifier.
- in_data  output  8  read data to the core.
- sw  input  8  raw slide switches, asynchronous.
- btn  input  NUM_BTN  raw push-buttons, asynchronous, active-high.
- led  output  8  LED register.
- seg_data  output  16  four 4-bit hex digits for the display driver.
- irq  output  1  event interrupt request (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values: led=0x00, seg_data=0x0000, irq=0, event flags=0, debounced levels=0, debounce counters=0, synchroniser flops=0.
- Write map (applied on clk edge when write_strobe=1):
  - 0x00 -> led.
  - 0x01 -> seg_data[7:0].
  - 0x02 -> seg_data[15:8].
  - 0x03 -> irq_mask (only under macro).
  - Other ids: ignored.
  - Write latency: output visible the cycle after the strobe edge.
- Read map: in_data is combinational from port_id with zero latency, valid whenever port_id is stable; read_strobe is not needed to drive data.
  - 0x00: sync_sw.
  - 0x01: debounced button levels, zero-extended.
  - 0x02: event flags, zero-extended.
  - 0x03: led readback.
  - 0x04: irq_mask (0x00 without macro).
  - Other ids: 0x00.
- Switch synchronisation: 2-flop synchroniser per bit. sw changes reach in_data at 0x00 after 2 clk edges.
- Button synchronisation: 2-flop synchroniser per button, then the debounce counter.
- Debounce, per button:
  - If the synced level equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the level still differs, the debounced level toggles and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is rejected.
  - Total press latency: 2 + DEBOUNCE_CYCLES cycles.
- Event flags:
  - A 0->1 transition of the debounced level sets flag[i].
  - read_strobe=1 with port_id=0x02 clears all flags that were set before that edge.
  - A new event on the same edge as the clear leaves its flag set (set has priority).
- Simultaneous read_strobe and write_strobe: each is processed independently; no interaction.
- Mid-operation reset: a partial debounce count is discarded; a held button becomes a new event after reset once it has debounced high.

Optional Feature:
- Macro: IO_PORT_CTRL_IRQ_EN.
- Defined:
  - An 8-bit irq_mask register exists (reset 0x00), written at 0x03 and read at 0x04.
  - irq is registered: irq <= |(flags & irq_mask[NUM_BTN-1:0]).
  - irq asserts 1 cycle after the flag sets and deasserts 1 cycle after the clear-on-read.
- Undefined:
  - irq is tied 0.
  - Writes to 0x03 are ignored; reads of 0x04 return 0x00.
  - No mask register is instantiated.

Decomposition:
- Package io_port_pkg holds:
  - Port address constants: PORT_LED=0x00, PORT_SEG_LO=0x01, PORT_SEG_HI=0x02, PORT_IRQ_MASK_W=0x03, PORT_SW=0x00, PORT_BTN_LVL=0x01, PORT_BTN_EVT=0x02, PORT_LED_RB=0x03, PORT_IRQ_MASK_R=0x04.
  - The default debounce constant.
- Sub-module btn_debounce (synchroniser + counter + rising-edge pulse) is instantiated NUM_BTN times by a generate loop.

Test Plan:
- Reset, then write_strobe with port_id=0x00, out_data=0xA5 -> led=0xA5 next cycle; reading 0x03 gives in_data=0xA5. Then assert reset -> led=0x00.
- Writes 0x34 to 0x01 and 0x12 to 0x02 -> seg_data=0x1234. A write to 0x07 leaves led and seg_data unchanged.
- sw=0x3C applied asynchronously, port_id=0x00 -> in_data=0x3C within 2 edges; port_id=0x55 -> in_data=0x00.
- DEBOUNCE_CYCLES=8:
  - btn[1] glitch high for 5 cycles -> 0x01 and 0x02 stay 0x00.
  - Held 12 cycles -> 0x01 reads 0x02 after 10 edges; 0x02 reads 0x02.
- Clear-on-read: flags=0x02, read_strobe at 0x02 -> 0x00 next cycle. A btn[0] debounced rise on the same edge as the clear -> flags=0x01.
- With IO_PORT_CTRL_IRQ_EN:
  - Mask 0x01, btn[2] event -> irq stays 0.
  - btn[0] event -> irq=1 one cycle after the flag sets.
  - Clear-on-read -> irq=0 one cycle later.
  - Without the macro, the same stimulus gives irq=0 throughout.
